// File: rtl/writeback_unit_pkg.sv
// Shared types and widths for the writeback arbiter and its load-result FIFO.
package writeback_unit_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [DATA_W-1:0]     data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Small load-result FIFO; push is ignored when full and pop is ignored when empty.
module wb_fifo
  import writeback_unit_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk_sys,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  wb_entry_t                  din,
  output wb_entry_t                  dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  wb_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Storage carries no reset; only the pointers and count define validity.
  always_ff @(posedge clk_sys) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/writeback_unit.sv
// Register-bank writeback arbiter: ALU results win, buffered loads fill idle cycles,
// and a busy scoreboard tracks outstanding load destinations for decode.
module writeback_unit
  import writeback_unit_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  ALU_VALID,
  input  logic [REG_ADDR_W-1:0] ALU_RD,
  input  logic [DATA_W-1:0]     ALU_DATA,
  input  logic                  MEM_VALID,
  input  logic [REG_ADDR_W-1:0] MEM_RD,
  input  logic [DATA_W-1:0]     MEM_DATA,
  output logic                  MEM_READY,
  input  logic                  ISSUE_VALID,
  input  logic [REG_ADDR_W-1:0] ISSUE_RD,
  output logic [31:0]           BUSY,
  output logic                  WAW_ERR,
  output logic                  REG_WRITE,
  output logic [REG_ADDR_W-1:0] WRITE_REGISTER,
  output logic [DATA_W-1:0]     WRITE_DATA
);

  localparam int CNT_W = $clog2(DEPTH+1);

  wb_entry_t        load_in;
  wb_entry_t        head;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  logic             push;
  logic             pop;
  logic [31:0]      busy_q;
  logic [31:0]      busy_next;

  assign load_in   = '{rd: MEM_RD, data: MEM_DATA};
  assign MEM_READY = !fifo_full;
  assign push      = MEM_VALID && MEM_READY;
  // Registered empty keeps an entry pushed this cycle from being popped this cycle.
  assign pop       = !ALU_VALID && !fifo_empty;
  assign BUSY      = busy_q;

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_sys (CLK),
    .rst     (RST),
    .push    (push),
    .pop     (pop),
    .din     (load_in),
    .dout    (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // Clear before set so a same-cycle issue to the retiring register keeps it busy.
  always_comb begin
    busy_next = busy_q;
    if (pop)         busy_next[head.rd]  = 1'b0;
    if (ISSUE_VALID) busy_next[ISSUE_RD] = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      REG_WRITE      <= 1'b0;
      WRITE_REGISTER <= '0;
      WRITE_DATA     <= '0;
      WAW_ERR        <= 1'b0;
      busy_q         <= '0;
    end else begin
      REG_WRITE <= 1'b0;
      if (ALU_VALID) begin
        if (ALU_RD != '0) begin
          REG_WRITE      <= 1'b1;
          WRITE_REGISTER <= ALU_RD;
          WRITE_DATA     <= ALU_DATA;
          if (busy_q[ALU_RD]) WAW_ERR <= 1'b1;
        end
      end else if (pop && head.rd != '0) begin
        REG_WRITE      <= 1'b1;
        WRITE_REGISTER <= head.rd;
        WRITE_DATA     <= head.data;
      end
      busy_q <= busy_next;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) assert (fifo_count <= CNT_W'(DEPTH));
  end

endmodule

// File: tb/tb_writeback_unit.sv
// Directed and randomized bench for writeback_unit against a queue-based reference model.
module tb_writeback_unit;

  localparam int DEPTH = 4;

  logic        CLK = 1'b0;
  logic        RST;
  logic        ALU_VALID, MEM_VALID, ISSUE_VALID;
  logic [4:0]  ALU_RD, MEM_RD, ISSUE_RD;
  logic [31:0] ALU_DATA, MEM_DATA;
  logic        MEM_READY, WAW_ERR, REG_WRITE;
  logic [31:0] BUSY;
  logic [4:0]  WRITE_REGISTER;
  logic [31:0] WRITE_DATA;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  ent_t        q[$];
  logic [31:0] m_busy;
  logic        m_waw, m_rw;
  logic [4:0]  m_wr;
  logic [31:0] m_wd;

  int checks = 0;
  int failures = 0;

  writeback_unit #(.DEPTH(DEPTH)) dut (
    .CLK            (CLK),
    .RST            (RST),
    .ALU_VALID      (ALU_VALID),
    .ALU_RD         (ALU_RD),
    .ALU_DATA       (ALU_DATA),
    .MEM_VALID      (MEM_VALID),
    .MEM_RD         (MEM_RD),
    .MEM_DATA       (MEM_DATA),
    .MEM_READY      (MEM_READY),
    .ISSUE_VALID    (ISSUE_VALID),
    .ISSUE_RD       (ISSUE_RD),
    .BUSY           (BUSY),
    .WAW_ERR        (WAW_ERR),
    .REG_WRITE      (REG_WRITE),
    .WRITE_REGISTER (WRITE_REGISTER),
    .WRITE_DATA     (WRITE_DATA)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_busy = '0;
    m_waw  = 1'b0;
    m_rw   = 1'b0;
    m_wr   = '0;
    m_wd   = '0;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".reg_write"}, {31'b0, REG_WRITE}, {31'b0, m_rw});
    check({tag, ".write_register"}, {27'b0, WRITE_REGISTER}, {27'b0, m_wr});
    check({tag, ".write_data"}, WRITE_DATA, m_wd);
    check({tag, ".busy"}, BUSY, m_busy);
    check({tag, ".waw_err"}, {31'b0, WAW_ERR}, {31'b0, m_waw});
  endtask

  // One clock of stimulus: drive at negedge, apply the rules at posedge, compare after it.
  task automatic cycle(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                       input logic mv, input logic [4:0] mr, input logic [31:0] md,
                       input logic iv, input logic [4:0] ir, output logic acc);
    int   size_before;
    ent_t e;
    @(negedge CLK);
    ALU_VALID = av; ALU_RD = ar; ALU_DATA = ad;
    MEM_VALID = mv; MEM_RD = mr; MEM_DATA = md;
    ISSUE_VALID = iv; ISSUE_RD = ir;
    #1;
    size_before = q.size();
    check("mem_ready", {31'b0, MEM_READY}, {31'b0, (size_before < DEPTH)});
    acc = mv && (size_before < DEPTH);
    @(posedge CLK);
    m_rw = 1'b0;
    if (av) begin
      if (ar != 0) begin
        m_rw = 1'b1; m_wr = ar; m_wd = ad;
        if (m_busy[ar]) m_waw = 1'b1;
      end
    end else if (size_before > 0) begin
      e = q.pop_front();
      if (e.rd != 0) begin
        m_rw = 1'b1; m_wr = e.rd; m_wd = e.data;
      end
      m_busy[e.rd] = 1'b0;
    end
    if (acc) q.push_back('{rd: mr, data: md});
    if (iv && ir != 0) m_busy[ir] = 1'b1;
    m_busy[0] = 1'b0;
    #1;
    check_outputs("cyc");
  endtask

  task automatic idle(input int n);
    logic acc;
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0, 0, acc);
  endtask

  initial begin
    logic acc;
    int   sent;
    RST = 1'b1;
    ALU_VALID = 0; ALU_RD = 0; ALU_DATA = 0;
    MEM_VALID = 0; MEM_RD = 0; MEM_DATA = 0;
    ISSUE_VALID = 0; ISSUE_RD = 0;
    model_reset();
    #1;
    check_outputs("reset");
    check("reset.mem_ready", {31'b0, MEM_READY}, 32'd1);
    @(negedge CLK); @(negedge CLK);
    RST = 1'b0;

    // ALU write, then hold.
    cycle(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, acc);
    check("alu.write_data", WRITE_DATA, 32'hDEADBEEF);
    check("alu.reg_write", {31'b0, REG_WRITE}, 32'd1);
    idle(1);
    check("alu.hold_reg", {27'b0, WRITE_REGISTER}, 32'd5);
    check("alu.pulse", {31'b0, REG_WRITE}, 32'd0);

    // Load latency and scoreboard clear.
    cycle(0, 0, 0, 0, 0, 0, 1, 8, acc);
    check("issue.busy8", {31'b0, BUSY[8]}, 32'd1);
    idle(2);
    cycle(0, 0, 0, 1, 8, 32'h12345678, 0, 0, acc);
    check("load.accept", {31'b0, acc}, 32'd1);
    check("load.not_yet", {31'b0, REG_WRITE}, 32'd0);
    idle(1);
    check("load.write", {31'b0, REG_WRITE}, 32'd1);
    check("load.data", WRITE_DATA, 32'h12345678);
    check("load.busy8_clr", {31'b0, BUSY[8]}, 32'd0);

    // ALU burst with loads queued behind it.
    sent = 0;
    for (int i = 0; i < 6; i++) begin
      cycle(1, 5'(10 + i), 32'hA000 + i, 1, 5'(20 + sent), 32'hB000 + sent, 0, 0, acc);
      if (acc) sent++;
    end
    check("burst.accepted", sent, 4);
    while (sent < 5) begin
      cycle(0, 0, 0, 1, 5'(20 + sent), 32'hB000 + sent, 0, 0, acc);
      if (acc) sent++;
    end
    idle(6);

    // Register 0 destinations are swallowed.
    cycle(0, 0, 0, 0, 0, 0, 1, 9, acc);
    cycle(1, 0, 32'h1111, 1, 0, 32'h2222, 0, 0, acc);
    check("r0.alu_no_write", {31'b0, REG_WRITE}, 32'd0);
    idle(3);

    // WAW detection and same-cycle set-wins.
    cycle(0, 0, 0, 0, 0, 0, 1, 3, acc);
    cycle(1, 3, 32'hCAFE0003, 0, 0, 0, 0, 0, acc);
    check("waw.set", {31'b0, WAW_ERR}, 32'd1);
    check("waw.write_data", WRITE_DATA, 32'hCAFE0003);
    cycle(0, 0, 0, 1, 3, 32'h33333333, 0, 0, acc);
    cycle(0, 0, 0, 0, 0, 0, 1, 3, acc);
    check("setwins.busy3", {31'b0, BUSY[3]}, 32'd1);
    check("setwins.write", {31'b0, REG_WRITE}, 32'd1);
    idle(2);
    check("waw.sticky", {31'b0, WAW_ERR}, 32'd1);

    // Asynchronous reset with buffered loads.
    cycle(1, 1, 32'h1, 1, 12, 32'hC1, 1, 12, acc);
    cycle(1, 2, 32'h2, 1, 13, 32'hC2, 1, 13, acc);
    cycle(1, 4, 32'h4, 1, 14, 32'hC3, 0, 0, acc);
    check("rst.pre_depth", q.size(), 3);
    @(posedge CLK);
    #3 RST = 1'b1;
    #1;
    model_reset();
    check_outputs("midrst");
    check("midrst.mem_ready", {31'b0, MEM_READY}, 32'd1);
    @(negedge CLK);
    ALU_VALID = 0; MEM_VALID = 0; ISSUE_VALID = 0;
    RST = 1'b0;
    idle(4);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      logic [4:0] r_a, r_m, r_i;
      r_a = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
      r_m = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
      r_i = 5'($urandom_range(0, 7));
      cycle(($urandom_range(0, 99) < ((i / 50) % 2 == 0 ? 40 : 75)), r_a, $urandom,
            ($urandom_range(0, 99) < 60), r_m, $urandom,
            ($urandom_range(0, 99) < 30), r_i, acc);
    end
    idle(8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/writeback_unit.md
# writeback_unit

Single-cycle writeback arbiter that drives the register bank's write port (REG_WRITE, WRITE_REGISTER, WRITE_DATA). It merges the non-stallable ALU result stream with the handshaked memory-load result stream, buffers load results in a small FIFO, and tracks outstanding load destinations in a busy scoreboard used by decode for hazard stalls. It sits between the execute/memory stages and the register bank, and is the only writer of the bank.

## Interface
- DEPTH, 4: load-result FIFO entries; power of two, ≥2.
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  asynchronous, active-high reset.
- ALU_VALID  in  1  ALU result present this cycle; never stalled.
- ALU_RD  in  5  ALU destination register.
- ALU_DATA  in  32  ALU result.
- MEM_VALID  in  1  load result offered.
- MEM_RD  in  5  load destination register.
- MEM_DATA  in  32  load data.
- MEM_READY  out  1  load result accepted when MEM_VALID && MEM_READY.
- ISSUE_VALID  in  1  a load is issued this cycle; marks ISSUE_RD busy.
- ISSUE_RD  in  5  destination of the issued load.
- BUSY  out  32  scoreboard; bit n = load to register n outstanding.
- WAW_ERR  out  1  sticky; ALU wrote a register marked busy.
- REG_WRITE  out  1  write strobe to register bank.
- WRITE_REGISTER  out  5  write address to register bank.
- WRITE_DATA  out  32  write data to register bank.

## Operation
- One bank write per cycle maximum. ALU has absolute priority; the FIFO head is written only in cycles with ALU_VALID=0.
- Load accept: MEM_VALID && MEM_READY enqueues {MEM_RD, MEM_DATA}. MEM_READY = !full (combinational from count).
- FIFO dequeue: when ALU_VALID=0 and FIFO not empty, head is popped and written.
- Register 0: writes with destination 0 (either source) are consumed (FIFO still pops) but REG_WRITE stays 0 and WRITE_* are not updated. ISSUE_RD=0 never sets BUSY[0]; BUSY[0] is constant 0.
- Scoreboard: BUSY[ISSUE_RD] set on ISSUE_VALID; BUSY[rd] cleared when a FIFO entry with that rd is written. Same-cycle set and clear of the same bit: set wins.
- WAW_ERR: set when ALU_VALID && ALU_RD≠0 && BUSY[ALU_RD]=1 (BUSY value before this cycle's update); cleared only by RST. The ALU write still proceeds.
- REG_WRITE is a one-cycle pulse per write; WRITE_REGISTER/WRITE_DATA hold their last written values when REG_WRITE=0 so the level-sensitive bank sees stable inputs.
- FIFO count width $clog2(DEPTH+1); pointers wrap modulo DEPTH. Simultaneous enqueue and dequeue when full is impossible (MEM_READY=0); when empty, an entry enqueued this cycle is not dequeued this cycle.

## Timing
- All outputs except MEM_READY are registered.
- ALU latency: ALU_VALID at edge N → REG_WRITE=1 with data after edge N (visible cycle N+1).
- Load latency, no ALU traffic: accept at edge N → enqueued; dequeued at edge N+1 → REG_WRITE visible cycle N+2.
- ISSUE_VALID at edge N → BUSY bit visible after edge N.
- Reset (async, any time, including mid-drain): REG_WRITE=0, WRITE_REGISTER=0, WRITE_DATA=0, BUSY=0, WAW_ERR=0, FIFO empty (MEM_READY=1). Buffered load results are discarded.

## Structure
- Shared package: REG_ADDR_W=5, DATA_W=32, wb_entry_t struct {rd[4:0], data[31:0]}.
- One sub-module: wb_fifo (parameterised DEPTH, push/pop, full/empty, count). Arbiter, scoreboard and WAW check live in writeback_unit.

## Test plan
- Reset then ALU_VALID=1, ALU_RD=5, ALU_DATA=0xDEADBEEF for one cycle → next cycle REG_WRITE=1, WRITE_REGISTER=5, WRITE_DATA=0xDEADBEEF; following cycle REG_WRITE=0, WRITE_* held.
- ISSUE_VALID rd=8; later MEM_VALID rd=8 data=0x12345678 with ALU idle → BUSY[8]=1 until write; REG_WRITE 2 cycles after accept; BUSY[8]=0 after that edge.
- ALU_VALID every cycle for 6 cycles while 5 loads offered → MEM_READY drops after 4 accepts, no load writes during ALU burst; loads written in order once ALU idles; 5th accepted after first pop.
- ALU_RD=0 and load rd=0 → REG_WRITE never asserted, FIFO drains, BUSY unchanged.
- ISSUE rd=3, then ALU write rd=3 → WAW_ERR=1 sticky, bank write of ALU data occurs; ISSUE rd=3 in same cycle as load rd=3 write → BUSY[3] stays 1.
- RST asserted mid-cycle with 3 FIFO entries and BUSY nonzero → all outputs zero immediately, MEM_READY=1, no stale writes after release.
